md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Controller that sequences the shared iterative multiplier and divider used by the execute stage.
- Latches operands when a multiply or divide instruction enters EXE, then holds the unit start level high until the unit reports completion.
- Captures the HI/LO result and holds it until MEM accepts it; drives the EXE completion and busy signals.
- Handles pipeline flush abort, divide-by-zero fast path and a watchdog timeout.

Parameters:
- MAX_CYCLES, 40, watchdog limit on cycles spent in RUN before a forced completion.
- CNT_W, 6, width of the cycle counter; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- exe_valid  in  1  EXE stage holds a valid instruction.
- exe_multiply  in  1  instruction is MULT/MULTU.
- exe_divide  in  1  instruction is DIV/DIVU.
- md_sign  in  1  signed operation.
- md_op1  in  32  rs operand, after bypass.
- md_op2  in  32  rt operand, after bypass.
- next_allow_in  in  1  MEM can accept this cycle.
- flush  in  1  exception/eret cancel from WB.
- mult_begin  out  1  multiplier start level.
- div_begin  out  1  divider start level.
- unit_sign  out  1  latched sign to both units.
- unit_op1  out  32  latched operand 1.
- unit_op2  out  32  latched operand 2.
- mult_end  in  1  multiplier done.
- product  in  64  multiplier result.
- div_end  in  1  divider done.
- quotient  in  32  divider quotient.
- remainder  in  32  divider remainder.
- md_over  out  1  result ready; EXE may advance.
- md_busy  out  1  state not IDLE.
- md_hi  out  32  HI result.
- md_lo  out  32  LO result.
- div_by_zero  out  1  completed divide had op2==0.
- md_timeout  out  1  completion was forced by the watchdog.

Behaviour:
- Reset: state=IDLE; all outputs 0; operand, result and counter registers 0.
- States: IDLE, MUL_RUN, DIV_RUN, DONE, ABORT.
- IDLE, exe_valid & (exe_multiply|exe_divide) & !flush:
  - Latch sign/op1/op2.
  - Multiply has priority if both flags are set.
  - Divide with md_op2==0: go directly to DONE with md_hi=md_op1, md_lo=32'hFFFFFFFF, div_by_zero=1. The divider is never started.
  - Otherwise go to MUL_RUN or DIV_RUN; cnt=0.
- MUL_RUN / DIV_RUN:
  - mult_begin or div_begin is held at 1 (level, not pulse); unit_* are stable.
  - cnt increments every cycle.
  - On the matching *_end: capture md_hi/md_lo and go to DONE.
    - Multiply: hi=product[63:32], lo=product[31:0].
    - Divide: hi=remainder, lo=quotient.
  - If cnt==MAX_CYCLES-1 without *_end: go to DONE with md_hi=md_lo=0 and md_timeout=1.
- DONE:
  - begin outputs are 0; md_over=1 (combinational on state).
  - Results, div_by_zero and md_timeout hold until next_allow_in=1, then go to IDLE.
  - An instruction can be accepted in IDLE on the following cycle, not the same cycle.
- Latency: a non-zero multiply/divide has md_over=1 exactly one cycle after the cycle *_end is seen. A div-by-zero has md_over=1 one cycle after acceptance.
- Flush in any non-IDLE state (priority over *_end, timeout and next_allow_in):
  - Go to ABORT. Begin outputs drop to 0 in the same registered update so the unit resets.
  - ABORT lasts exactly 1 cycle, then IDLE; md_over=0; results are not updated.
- Flush in IDLE blocks acceptance that cycle.
- md_busy = (state != IDLE).
- Flag clearing: div_by_zero and md_timeout clear on leaving DONE.
- md_hi/md_lo retain their last values in IDLE.
- A *_end arriving outside RUN is ignored. A non-matching *_end (e.g. div_end in MUL_RUN) is ignored.
- Operands sampled in IDLE are immune to later bypass changes on md_op1/md_op2.
- Reset asserted mid-operation: immediate return to IDLE and all outputs 0, regardless of state.

Decomposition:
- Shared package:
  - State encoding (3-bit localparams S_IDLE=0, S_MUL=1, S_DIV=2, S_DONE=3, S_ABORT=4).
  - DIV0_LO constant 32'hFFFFFFFF.
- One natural sub-module: md_watchdog (cycle counter plus expiry compare, clear/enable inputs).
- The FSM, operand latch and result registers stay in md_sched.

Test Plan:
- MULT signed, op1=-3, op2=7; mult_end after 33 cycles, product=64'hFFFFFFFF_FFFFFFEB -> mult_begin high 33 cycles; md_over next cycle; md_hi=FFFFFFFF, md_lo=FFFFFFEB.
- DIVU op1=100, op2=7; div_end with q=14, r=2; next_allow_in=0 for 3 cycles in DONE -> md_over held 4 cycles; md_hi=2, md_lo=14 stable; IDLE after accept.
- DIV op1=5, op2=0 -> div_begin never 1; md_over one cycle after acceptance; md_hi=5, md_lo=FFFFFFFF, div_by_zero=1.
- MULT started, flush at cycle 10 concurrent with mult_end -> ABORT for 1 cycle; mult_begin=0; md_over never 1; md_hi/md_lo unchanged.
- DIV with div_end never asserted; MAX_CYCLES=40 -> DONE after 40 RUN cycles; md_timeout=1; md_hi=md_lo=0.
- Reset asserted asynchronously mid-MUL_RUN -> md_busy, mult_begin and md_over go 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/md_sched_pkg.sv
// Shared state encoding, constants and result type for the multiply/divide scheduler.
package md_sched_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL   = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

endpackage

// File: rtl/md_sched_if.sv
// Bundle of EXE-stage, MEM-handshake and arithmetic-unit signals around md_sched.
interface md_sched_if;
    logic        exe_valid;
    logic        exe_multiply;
    logic        exe_divide;
    logic        md_sign;
    logic [31:0] md_op1;
    logic [31:0] md_op2;
    logic        next_allow_in;
    logic        flush;
    logic        mult_begin;
    logic        div_begin;
    logic        unit_sign;
    logic [31:0] unit_op1;
    logic [31:0] unit_op2;
    logic        mult_end;
    logic [63:0] product;
    logic        div_end;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        md_over;
    logic        md_busy;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        div_by_zero;
    logic        md_timeout;

    modport master (
        input  exe_valid, exe_multiply, exe_divide, md_sign, md_op1, md_op2,
               next_allow_in, flush, mult_end, product, div_end, quotient, remainder,
        output mult_begin, div_begin, unit_sign, unit_op1, unit_op2,
               md_over, md_busy, md_hi, md_lo, div_by_zero, md_timeout
    );

    modport slave (
        output exe_valid, exe_multiply, exe_divide, md_sign, md_op1, md_op2,
               next_allow_in, flush, mult_end, product, div_end, quotient, remainder,
        input  mult_begin, div_begin, unit_sign, unit_op1, unit_op2,
               md_over, md_busy, md_hi, md_lo, div_by_zero, md_timeout
    );
endinterface

// File: rtl/md_sched_watchdog.sv
// Cycle counter for the RUN states; expired_o flags the last permitted cycle.
module md_watchdog #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired_o = en_i && (cnt_q == CNT_W'(MAX_CYCLES - 1));
endmodule

// File: rtl/md_sched.sv
// Sequences the shared iterative multiplier/divider: latches operands, holds the unit
// start level until done, and holds HI/LO in DONE until MEM accepts.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic      clk,
    input  logic      reset,
    md_sched_if.master bus
);
    logic [2:0]  state_q, state_d;
    logic        sign_q, sign_d;
    logic [31:0] op1_q, op1_d, op2_q, op2_d;
    md_res_t     res_q, res_d;
    logic        dbz_q, dbz_d, to_q, to_d;
    logic        wd_clr, wd_en, wd_expired;

    md_watchdog #(.MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)) u_wd (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        res_d   = res_q;
        dbz_d   = dbz_q;
        to_d    = to_q;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.exe_valid && (bus.exe_multiply || bus.exe_divide) && !bus.flush) begin
                    sign_d = bus.md_sign;
                    op1_d  = bus.md_op1;
                    op2_d  = bus.md_op2;
                    wd_clr = 1'b1;
                    if (bus.exe_multiply) begin
                        state_d = S_MUL;
                    end else if (bus.md_op2 == 32'd0) begin
                        // Divide by zero completes without ever starting the divider.
                        state_d = S_DONE;
                        res_d   = '{hi: bus.md_op1, lo: DIV0_LO};
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                wd_en = 1'b1;
                if (bus.flush) begin
                    state_d = S_ABORT;
                end else if (state_q == S_MUL && bus.mult_end) begin
                    state_d = S_DONE;
                    res_d   = '{hi: bus.product[63:32], lo: bus.product[31:0]};
                end else if (state_q == S_DIV && bus.div_end) begin
                    state_d = S_DONE;
                    res_d   = '{hi: bus.remainder, lo: bus.quotient};
                end else if (wd_expired) begin
                    state_d = S_DONE;
                    res_d   = '0;
                    to_d    = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.flush) begin
                    state_d = S_ABORT;
                    dbz_d   = 1'b0;
                    to_d    = 1'b0;
                end else if (bus.next_allow_in) begin
                    state_d = S_IDLE;
                    dbz_d   = 1'b0;
                    to_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            dbz_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
            to_q    <= to_d;
        end
    end

    assign bus.mult_begin  = (state_q == S_MUL);
    assign bus.div_begin   = (state_q == S_DIV);
    assign bus.unit_sign   = sign_q;
    assign bus.unit_op1    = op1_q;
    assign bus.unit_op2    = op2_q;
    assign bus.md_over     = (state_q == S_DONE);
    assign bus.md_busy     = (state_q != S_IDLE);
    assign bus.md_hi       = res_q.hi;
    assign bus.md_lo       = res_q.lo;
    assign bus.div_by_zero = dbz_q;
    assign bus.md_timeout  = to_q;
endmodule

// File: tb/tb_md_sched.sv
// Directed vector bench for md_sched: table of full transactions plus flush and reset sequences.
module tb_md_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    md_sched_if bus();

    md_sched #(.MAX_CYCLES(40), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mul;
        logic        div;
        logic        sign;
        logic [31:0] op1;
        logic [31:0] op2;
        int          lat;      // begin-high cycle on which *_end fires; 0 = never
        logic [63:0] res;      // product, or {remainder, quotient}
        int          hold;     // DONE cycles with next_allow_in low
        int          exp_beg;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
        logic        exp_to;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n = 0;
        int wrong = 0;
        @(negedge clk);
        chk($sformatf("v%0d idle busy", idx), 64'(bus.md_busy), 64'd0);
        bus.exe_valid = 1'b1;
        bus.exe_multiply = v.mul;
        bus.exe_divide = v.div;
        bus.md_sign = v.sign;
        bus.md_op1 = v.op1;
        bus.md_op2 = v.op2;
        @(negedge clk);
        bus.exe_valid = 1'b0;
        bus.md_op1 = 32'hDEAD_BEEF;
        bus.md_op2 = 32'hCAFE_F00D;
        // Drive the non-matching completion high with junk data; it must be ignored.
        if (v.mul) begin
            bus.div_end = 1'b1;
            bus.quotient = 32'hBAD0_0001;
            bus.remainder = 32'hBAD0_0002;
        end else begin
            bus.mult_end = 1'b1;
            bus.product = 64'hBAD0_0003_BAD0_0004;
        end
        for (int i = 0; i < 200; i++) begin
            if (!(bus.mult_begin || bus.div_begin)) break;
            if ((v.mul && bus.div_begin) || (!v.mul && bus.mult_begin)) wrong++;
            n++;
            if (n == v.lat) begin
                if (v.mul) begin
                    bus.mult_end = 1'b1;
                    bus.product = v.res;
                end else begin
                    bus.div_end = 1'b1;
                    bus.remainder = v.res[63:32];
                    bus.quotient = v.res[31:0];
                end
            end
            @(negedge clk);
        end
        bus.mult_end = 1'b0;
        bus.div_end = 1'b0;
        chk($sformatf("v%0d begin cycles", idx), 64'(n), 64'(v.exp_beg));
        chk($sformatf("v%0d wrong unit", idx), 64'(wrong), 64'd0);
        chk($sformatf("v%0d unit ops", idx), {bus.unit_op1, bus.unit_op2}, {v.op1, v.op2});
        chk($sformatf("v%0d unit sign", idx), 64'(bus.unit_sign), 64'(v.sign));
        for (int h = 0; h <= v.hold; h++) begin
            if (h == v.hold) bus.next_allow_in = 1'b1;
            chk($sformatf("v%0d over c%0d", idx, h), 64'(bus.md_over), 64'd1);
            chk($sformatf("v%0d hi/lo c%0d", idx, h), {bus.md_hi, bus.md_lo}, {v.exp_hi, v.exp_lo});
            chk($sformatf("v%0d flags c%0d", idx, h), {62'd0, bus.div_by_zero, bus.md_timeout},
                {62'd0, v.exp_dbz, v.exp_to});
            @(negedge clk);
        end
        bus.next_allow_in = 1'b0;
        chk($sformatf("v%0d after accept", idx),
            {60'd0, bus.md_busy, bus.md_over, bus.div_by_zero, bus.md_timeout}, 64'd0);
        chk($sformatf("v%0d hi/lo retained", idx), {bus.md_hi, bus.md_lo}, {v.exp_hi, v.exp_lo});
    endtask

    task automatic flush_seq(input logic [31:0] prev_hi, input logic [31:0] prev_lo);
        int n = 0;
        int over_seen = 0;
        @(negedge clk);
        bus.exe_valid = 1'b1;
        bus.exe_multiply = 1'b1;
        bus.exe_divide = 1'b0;
        bus.md_op1 = 32'd3;
        bus.md_op2 = 32'd4;
        @(negedge clk);
        bus.exe_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.md_over) over_seen++;
            if (bus.mult_begin) n++;
            if (n == 10) begin
                bus.mult_end = 1'b1;
                bus.product = 64'd12;
                bus.flush = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("flush reach cycle10", 64'(n), 64'd10);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.mult_end = 1'b0;
        chk("abort busy/begin/over", {61'd0, bus.md_busy, bus.mult_begin, bus.md_over}, 64'b100);
        @(negedge clk);
        chk("abort one cycle", {62'd0, bus.md_busy, bus.md_over}, 64'd0);
        chk("abort over never", 64'(over_seen), 64'd0);
        chk("abort hi/lo unchanged", {bus.md_hi, bus.md_lo}, {prev_hi, prev_lo});
        // Flush in IDLE must block acceptance.
        bus.exe_valid = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.exe_valid = 1'b0;
        bus.flush = 1'b0;
        chk("idle flush blocks", 64'(bus.md_busy), 64'd0);
    endtask

    task automatic reset_seq();
        @(negedge clk);
        bus.exe_valid = 1'b1;
        bus.exe_multiply = 1'b1;
        bus.md_op1 = 32'd7;
        bus.md_op2 = 32'd8;
        @(negedge clk);
        bus.exe_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre-reset running", {62'd0, bus.md_busy, bus.mult_begin}, 64'b11);
        #2 reset = 1'b1;
        #1;
        chk("async reset ctrl", {61'd0, bus.md_busy, bus.mult_begin, bus.md_over}, 64'd0);
        chk("async reset data", {bus.md_hi, bus.md_lo}, 64'd0);
        chk("async reset ops", {bus.unit_op1, bus.unit_op2}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset idle", {62'd0, bus.md_busy, bus.mult_begin}, 64'd0);
    endtask

    initial begin
        bus.exe_valid = 1'b0;
        bus.exe_multiply = 1'b0;
        bus.exe_divide = 1'b0;
        bus.md_sign = 1'b0;
        bus.md_op1 = '0;
        bus.md_op2 = '0;
        bus.next_allow_in = 1'b0;
        bus.flush = 1'b0;
        bus.mult_end = 1'b0;
        bus.product = '0;
        bus.div_end = 1'b0;
        bus.quotient = '0;
        bus.remainder = '0;

        //          mul   div   sgn   op1            op2           lat res                     hold beg hi             lo             dbz   to
        vecs[0] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7,        33, 64'hFFFFFFFF_FFFFFFEB, 0,  33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'd100,       32'd7,        5,  {32'd2, 32'd14},       3,  5,  32'd2,         32'd14,        1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'd5,         32'd0,        0,  64'd0,                 1,  0,  32'd5,         32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'd9,         32'd3,        0,  64'd0,                 2,  40, 32'd0,         32'd0,         1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h1234,      32'd0,        3,  64'd0,                 0,  3,  32'd0,         32'd0,         1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 1, 64'h1_0000_0000,       0,  1,  32'd1,         32'd0,         1'b0, 1'b0};

        #1;
        chk("reset outputs", {56'd0, bus.mult_begin, bus.div_begin, bus.unit_sign, bus.md_over,
            bus.md_busy, bus.div_by_zero, bus.md_timeout, 1'b0}, 64'd0);
        chk("reset hi/lo", {bus.md_hi, bus.md_lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
        flush_seq(vecs[5].exp_hi, vecs[5].exp_lo);
        reset_seq();
        run_vec(6, vecs[5]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
